// File: rtl/nibble_serial_add_ctrl.sv
// Full-width adder controller that streams operands one nibble per cycle
// through an external 4-bit ripple-carry stage and rebuilds the sum.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [3:0]       add_x,
    output logic [3:0]       add_y,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_sa;
    logic             r_sb;
    logic             r_cout;
    logic             r_ovf;
    logic             r_outValid;

    logic             w_run;
    logic             w_last;
    logic [WIDTH+3:0] w_cat;

    assign w_run  = (r_state == RUN);
    assign w_last = (r_cnt == CW'(NIBBLES - 1));
    // New sum nibble enters at the top; after NIBBLES passes nibble 0 sits at the bottom.
    assign w_cat  = {add_s, r_result};

    assign in_ready  = (r_state == IDLE);
    assign add_x     = w_run ? r_a[3:0] : 4'd0;
    assign add_y     = w_run ? r_b[3:0] : 4'd0;
    assign add_cin   = w_run ? r_carry  : 1'b0;
    assign out_valid = r_outValid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_carry <= cin;
                        r_sa    <= op_a[WIDTH-1];
                        r_sb    <= op_b[WIDTH-1];
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result <= w_cat[WIDTH+3:4];
                    r_carry  <= add_cout;
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout     <= add_cout;
                        r_ovf      <= (r_sa == r_sb) && (add_s[3] != r_sa);
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized bench for nibble_serial_add_ctrl with a behavioural 4-bit adder
// and a whole-word arithmetic reference model.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [3:0]       add_x;
    logic [3:0]       add_y;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    int checkCount = 0;
    int errCount   = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    // The external ripple-carry stage, modelled as plain addition.
    assign {add_cout, add_s} = 5'(add_x) + 5'(add_y) + 5'(add_cin);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete operation: accept, per-pass adder drive, result, backpressure, release.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input int holdCycles, input bit pulseInValid);
        logic [WIDTH:0] sum;
        logic           expOvf;
        logic [31:0]    mask;
        logic [31:0]    carryIn;
        int             w;

        sum    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
        expOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        checkOutput("adder_idle", 32'({add_x, add_y, add_cin}), 32'd0);

        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        cin      = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = WIDTH'($urandom);
        op_b     = WIDTH'($urandom);
        cin      = 1'($urandom);

        for (int k = 0; k < NIBBLES; k++) begin
            mask    = (32'd1 << (4 * k)) - 32'd1;
            carryIn = ((32'(a) & mask) + (32'(b) & mask) + 32'(c)) >> (4 * k);
            checkOutput("out_valid_run", 32'(out_valid), 32'd0);
            checkOutput("in_ready_run", 32'(in_ready), 32'd0);
            checkOutput("add_x", 32'(add_x), (32'(a) >> (4 * k)) & 32'hF);
            checkOutput("add_y", 32'(add_y), (32'(b) >> (4 * k)) & 32'hF);
            checkOutput("add_cin", 32'(add_cin), carryIn & 32'd1);
            @(negedge clk);
        end

        checkOutput("out_valid_latency", 32'(out_valid), 32'd1);
        checkOutput("result", 32'(result), 32'(sum[WIDTH-1:0]));
        checkOutput("cout", 32'(cout), 32'(sum[WIDTH]));
        checkOutput("overflow", 32'(overflow), 32'(expOvf));

        for (int h = 0; h < holdCycles; h++) begin
            if (pulseInValid) begin
                in_valid = 1'($urandom);
                op_a     = WIDTH'($urandom);
                op_b     = WIDTH'($urandom);
                cin      = 1'($urandom);
            end
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_result", 32'(result), 32'(sum[WIDTH-1:0]));
            checkOutput("hold_cout", 32'(cout), 32'(sum[WIDTH]));
            checkOutput("hold_overflow", 32'(overflow), 32'(expOvf));
        end

        // in_valid stays high across the release edge; it must not be taken there.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a      = WIDTH'($urandom);
        op_b      = WIDTH'($urandom);
        @(negedge clk);
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("release_result", 32'(result), 32'(sum[WIDTH-1:0]));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("no_same_cycle_accept", 32'(in_ready), 32'd1);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        applyStimulus(16'h000F, 16'h0000, 1'b1, 0, 1'b0);
        applyStimulus(16'hABCD, 16'h1111, 1'b1, 5, 1'b1);

        // Abort an operation two passes in.
        in_valid = 1'b1;
        op_a     = 16'h1234;
        op_b     = 16'h4321;
        cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_add_x", 32'(add_x), 32'd0);
        checkOutput("abort_add_y", 32'(add_y), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_stays_invalid", 32'(out_valid), 32'd0);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, errCount);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequential controller that adds two WIDTH-bit operands by streaming them, one nibble per cycle, through the team's existing 4-bit ripple-carry adder stage. It sits directly upstream of that adder, driving its X/Y/Cin inputs. It sits directly downstream of it, consuming S/Cout and assembling the full-width result. Operands arrive and results leave through valid/ready handshakes.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived local constant: number of adder passes per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands (high only in IDLE)
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  carry-in of the full-width add
add_x  output  4  to adder X: current A nibble
add_y  output  4  to adder Y: current B nibble
add_cin  output  1  to adder Cin: running carry
add_s  input  4  from adder S
add_cout  input  1  from adder Cout
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  op_a + op_b + cin, modulo 2^WIDTH
cout  output  1  unsigned carry-out of the full add
overflow  output  1  two's-complement overflow

Behaviour:
- Reset: the block is forced to IDLE asynchronously. All of the following clear to 0: operand shift registers, result register, carry register, nibble counter, cout, overflow, out_valid. in_ready is 1 once rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: load op_a/op_b into shift regs A/B and set carry_reg=cin.
  - Latch sa=op_a[WIDTH-1] and sb=op_b[WIDTH-1], clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - add_x=A[3:0], add_y=B[3:0], add_cin=carry_reg. These paths are combinational from registers.
  - At each edge:
    - result <= {add_s, result[WIDTH-1:4]} (result shifts right, new nibble enters at the top).
    - carry_reg <= add_cout.
    - A and B shift right by 4.
    - counter increments.
  - On the edge where counter == NIBBLES-1, also:
    - cout <= add_cout.
    - overflow <= (sa==sb) && (add_s[3]!=sa).
    - out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1, in_ready=0. result, cout and overflow are held stable.
  - When out_ready is high at an edge: out_valid <= 0, go to IDLE. result, cout and overflow keep their values until the next operation completes.
- Outside RUN, add_x=0, add_y=0, add_cin=0.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge (4 cycles for WIDTH=16). Throughput is one operation per NIBBLES+2 cycles minimum.
- Simultaneous events:
  - DONE with out_ready=1 and in_valid=1: no same-cycle accept, because in_ready is 0 in DONE. The accept occurs in the following IDLE cycle.
  - in_valid while in_ready=0 is ignored. Operands need not be held by upstream after acceptance.
- Reset mid-RUN or mid-DONE: the operation is discarded and all outputs return to reset values immediately. No partial result is ever flagged valid.
- The adder interface is purely combinational, so within one cycle add_s/add_cout correspond to that cycle's add_x/add_y/add_cin.
- Width rule: all arithmetic is mod 2^WIDTH. cout equals bit WIDTH of the exact sum.

Test Plan:
- WIDTH=16, op_a=0x1234, op_b=0x4321, cin=0 -> result=0x5555, cout=0, overflow=0; out_valid exactly 4 cycles after accept.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1, overflow=0 (carry ripples through all four nibbles).
- op_a=0x7FFF, op_b=0x0001, cin=0 -> result=0x8000, cout=0, overflow=1; op_a=0x8000, op_b=0x8000 -> result=0x0000, cout=1, overflow=1.
- op_a=0x000F, op_b=0x0000, cin=1 -> result=0x0010, cout=0; check add_cin=1 on the nibble-1 pass.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/cout/overflow stable, in_ready=0, in_valid pulses ignored; release -> out_valid drops next edge, in_ready=1.
- Assert rst during RUN after 2 nibbles -> out_valid=0, result=0, add_x/add_y=0 immediately. After release, a new 0x0001+0x0001 yields 0x0002.
